// File: rtl/endian_conv_pipe.sv
// Per-lane bit/byte-order converter feeding a 2-entry registered output FIFO.
// Modes: 0 pass, 1 full bit-reverse, 2 byte-swap, 3 bit-reverse within each byte.
module endian_conv_pipe #(
    parameter int CH     = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_mode,
    output logic [CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int W     = CH * DATA_W;

    localparam logic [1:0] MODE_BITREV         = 2'd1;
    localparam logic [1:0] MODE_BYTESWAP       = 2'd2;
    localparam logic [1:0] MODE_BITREV_IN_BYTE = 2'd3;

    generate
        if (DATA_W % 8 != 0 || DATA_W == 0) begin : g_bad_width
            $error("endian_conv_pipe: DATA_W must be a non-zero multiple of 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    logic [W-1:0] rev_bits;
    logic [W-1:0] swap_bytes;
    logic [W-1:0] rev_in_byte;
    logic [W-1:0] conv_data;

    // Each transform is a fixed wire permutation inside one lane.
    for (genvar k = 0; k < CH; k++) begin : g_lane
        for (genvar i = 0; i < DATA_W; i++) begin : g_bit
            localparam int LO = k * DATA_W;
            assign rev_bits[LO + i]                              = in_data[LO + DATA_W - 1 - i];
            assign swap_bytes[LO + (BYTES - 1 - i / 8) * 8 + i % 8] = in_data[LO + i];
            assign rev_in_byte[LO + (i / 8) * 8 + 7 - i % 8]     = in_data[LO + i];
        end
    end

    always_comb begin
        conv_data = in_data;
        case (in_mode)
            MODE_BITREV:         conv_data = rev_bits;
            MODE_BYTESWAP:       conv_data = swap_bytes;
            MODE_BITREV_IN_BYTE: conv_data = rev_in_byte;
            default:             conv_data = in_data;
        endcase
    end

    // Handshake: a beat moves on an edge where valid & ready are both 1; valid
    // never waits on ready, and in_ready is registered (no path from out_ready).
    occ_e         occ;
    logic [W-1:0] tail_data;
    logic [1:0]   tail_mode;
    logic         push;
    logic         pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= OCC_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
            tail_data <= '0;
            tail_mode <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        out_data  <= conv_data;
                        out_mode  <= in_mode;
                        out_valid <= 1'b1;
                        occ       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        out_data <= conv_data;
                        out_mode <= in_mode;
                    end else if (push) begin
                        tail_data <= conv_data;
                        tail_mode <= in_mode;
                        in_ready  <= 1'b0;
                        occ       <= OCC_FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        occ       <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        out_data <= tail_data;
                        out_mode <= tail_mode;
                        in_ready <= 1'b1;
                        occ      <= OCC_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    occ       <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_endian_conv_pipe.sv
// Directed bench for endian_conv_pipe: queue-based reference model checked every
// cycle, plus literal expectations for the documented vectors.
module tb_endian_conv_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_mode;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready,  in_ready_w;
    logic        out_valid, out_valid_w;
    logic [1:0]  out_mode,  out_mode_w;
    logic [31:0] out_data,  out_data_w;
    logic [15:0] xfer_cnt;
    logic [3:0]  xfer_cnt_w;

    int vectors    = 0;
    int miscompares = 0;

    logic [33:0] exp_q[$];
    logic [31:0] seen_q[$];
    logic [33:0] model_last = '0;
    int unsigned model_cnt  = 0;
    bit          model_live = 1'b0;

    always #5 clk = ~clk;

    endian_conv_pipe #(.CH(2), .DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .xfer_cnt(xfer_cnt)
    );

    endian_conv_pipe #(.CH(2), .DATA_W(16), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_mode(out_mode_w), .out_data(out_data_w),
        .xfer_cnt(xfer_cnt_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_conv(input logic [1:0] m, input logic [31:0] d);
        logic [15:0] l, r, b;
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < 2; k++) begin
            l = d[k*16 +: 16];
            case (m)
                2'd1: r = {<<{l}};
                2'd2: r = {<<8{l}};
                2'd3: begin
                    b = {<<{l}};
                    r = {<<8{b}};
                end
                default: r = l;
            endcase
            res[k*16 +: 16] = r;
        end
        return res;
    endfunction

    // Reference model: advances on each rising edge from the inputs seen there.
    always @(posedge clk) begin
        bit can_pop, can_push;
        model_live = 1'b1;
        if (rst) begin
            exp_q.delete();
            model_cnt  = 0;
            model_last = '0;
        end else begin
            can_pop  = (exp_q.size() != 0) && out_ready;
            can_push = in_valid && (exp_q.size() != 2);
            if (can_pop) begin
                void'(exp_q.pop_front());
                model_cnt++;
            end
            if (can_push) exp_q.push_back({in_mode, model_conv(in_mode, in_data)});
            if (exp_q.size() != 0) model_last = exp_q[0];
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("in_ready",  64'(in_ready),  64'(exp_q.size() != 2));
            chk("out_data",  64'(out_data),  64'(model_last[31:0]));
            chk("out_mode",  64'(out_mode),  64'(model_last[33:32]));
            chk("xfer_cnt",  64'(xfer_cnt),  64'(model_cnt[15:0]));
            chk("xfer_cnt_w4", 64'(xfer_cnt_w), 64'(model_cnt[3:0]));
            chk("out_data_w4", 64'(out_data_w), 64'(model_last[31:0]));
            if (out_valid && out_ready) seen_q.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        seen_q.delete();
    endtask

    task automatic push_beat(input logic [1:0] m, input logic [31:0] d);
        int t = 0;
        in_mode  = m;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        chk("push_wait_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_seen(input string name, input int n, input int budget);
        int t = 0;
        while (seen_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(name, 64'(seen_q.size()), 64'(n));
    endtask

    function automatic logic [31:0] seen_at(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic one_beat(input string name, input logic [1:0] m, input logic [31:0] d,
                            input logic [31:0] exp);
        in_mode  = m;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"},  64'(out_data),  64'(exp));
        chk({name, "_mode"},  64'(out_mode),  64'(m));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d5[8];

        chk("pin_bitrev",   64'(model_conv(2'd1, 32'h000A_0005)), 64'h5000_A000);
        chk("pin_byteswap", 64'(model_conv(2'd2, 32'h1234_1234)), 64'h3412_3412);
        chk("pin_rib",      64'(model_conv(2'd3, 32'h0180_0180)), 64'h8001_8001);

        // Reset held two cycles with a beat offered: nothing may enter.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_data   = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        tick();
        chk("rst_nothing_enq", 64'(out_valid), 64'd0);

        // Single bit-reversed beat, one-cycle latency.
        out_ready = 1'b1;
        in_mode   = 2'd1;
        in_data   = 32'h000A_0005;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bitrev_valid", 64'(out_valid), 64'd1);
        chk("bitrev_data",  64'(out_data),  64'h5000_A000);
        chk("bitrev_mode",  64'(out_mode),  64'd1);
        tick();
        chk("bitrev_one_cycle", 64'(out_valid), 64'd0);
        chk("bitrev_cnt",       64'(xfer_cnt),  64'd1);

        one_beat("byteswap", 2'd2, 32'hABCD_1234, 32'hCDAB_3412);
        one_beat("rib",      2'd3, 32'h0180_0F01, 32'h8001_F080);
        one_beat("pass",     2'd0, 32'hBEEF_BEEF, 32'hBEEF_BEEF);
        chk("after_modes_cnt", 64'(xfer_cnt), 64'd4);

        // Backpressure: A and B fill the buffer, C stalls until space frees.
        reset_dut();
        out_ready = 1'b0;
        push_beat(2'd0, 32'h1111_2222);
        push_beat(2'd0, 32'h3333_4444);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_head_a",     64'(out_data), 64'h1111_2222);
        in_mode  = 2'd0;
        in_data  = 32'h5555_6666;
        in_valid = 1'b1;
        tick();
        tick();
        chk("bp_stall_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_a",      64'(out_data), 64'h1111_2222);
        out_ready = 1'b1;
        for (int t = 0; t < 10 && !in_ready; t++) tick();
        tick();
        in_valid = 1'b0;
        wait_seen("bp_count", 3, 10);
        chk("bp_order_a", 64'(seen_at(0)), 64'h1111_2222);
        chk("bp_order_b", 64'(seen_at(1)), 64'h3333_4444);
        chk("bp_order_c", 64'(seen_at(2)), 64'h5555_6666);
        chk("bp_cnt",     64'(xfer_cnt),   64'd3);

        // Simultaneous push and pop at occupancy 1 for 8 cycles.
        reset_dut();
        out_ready = 1'b0;
        push_beat(2'd2, 32'h0102_0304);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d5[i]   = 32'hA5C3_0F01 + 32'(i) * 32'h0101_0101;
            in_mode = 2'(i % 4);
            in_data = d5[i];
            chk("simul_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        wait_seen("simul_count", 9, 10);
        chk("simul_first", 64'(seen_at(0)), 64'h0201_0403);
        for (int i = 0; i < 8; i++)
            chk("simul_beat", 64'(seen_at(i + 1)), 64'(model_conv(2'(i % 4), d5[i])));
        chk("simul_cnt", 64'(xfer_cnt), 64'd9);

        // Reset coinciding with both handshakes: reset wins.
        out_ready = 1'b0;
        push_beat(2'd1, 32'h8000_0001);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        rst       = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_hs_valid", 64'(out_valid), 64'd0);
        chk("rst_hs_cnt",   64'(xfer_cnt),  64'd0);
        tick();
        chk("rst_hs_no_push", 64'(out_valid), 64'd0);

        // Reset with two beats buffered: they are never delivered.
        seen_q.delete();
        out_ready = 1'b0;
        push_beat(2'd0, 32'hDEAD_0001);
        push_beat(2'd0, 32'hDEAD_0002);
        chk("mid_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_cnt",   64'(xfer_cnt),  64'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("mid_discarded", 64'(seen_q.size()), 64'd0);

        // Counter wrap on the CNT_W=4 instance after 16 transfers.
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push_beat(2'(i % 4), 32'h0100_0001 * 32'(i + 1));
        wait_seen("wrap_count", 16, 10);
        chk("wrap_cnt16", 64'(xfer_cnt),   64'd16);
        chk("wrap_cnt4",  64'(xfer_cnt_w), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
